result_history_buffer: RTL and testbench
========================================

RESULT_HISTORY_BUFFER -- requirements
Module: result_history_buffer

Interface
REQ-001 Parameter DEPTH, 8, number of stored result entries; SHALL be a power of two, 2..16.
REQ-002 Parameter ADDR_W, 3, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; every state element SHALL be clocked on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  single-cycle strobe: capture the current ALU outputs.
REQ-006 result_in  input  16  ALU result.
REQ-007 rem_in  input  4  ALU remainder display value.
REQ-008 div_flag_in  input  1  ALU divide-valid flag.
REQ-009 prev_btn  input  1  debounced level: step to the next-older entry.
REQ-010 next_btn  input  1  debounced level: step to the next-newer entry.
REQ-011 clear  input  1  synchronous history flush.
REQ-012 disp_result  output  16  registered result of the viewed entry.
REQ-013 disp_rem  output  4  registered remainder of the viewed entry.
REQ-014 disp_div_flag  output  1  registered divide flag of the viewed entry.
REQ-015 view_offset  output  ADDR_W  age of the viewed entry; 0 = newest.
REQ-016 count  output  ADDR_W+1  number of valid entries, 0..DEPTH.
REQ-017 empty / full  output  1 each  empty = (count==0); full = (count==DEPTH).

Function
REQ-018 Each entry SHALL be 21 bits: {div_flag, rem, result}.
REQ-019 On wr_en, the entry SHALL be written at wr_ptr, and wr_ptr SHALL increment modulo DEPTH.
REQ-020 On wr_en, count SHALL increment and saturate at DEPTH; when full, the write SHALL overwrite the oldest entry.
REQ-021 On wr_en, view_offset SHALL be forced to 0.
REQ-022 The block SHALL detect rising edges on prev_btn and next_btn internally; a held button SHALL produce exactly one step.
REQ-023 A prev edge SHALL increment view_offset, saturating at count-1; a next edge SHALL decrement view_offset, saturating at 0.
REQ-024 The viewed address SHALL be (wr_ptr - 1 - view_offset) mod DEPTH.
REQ-025 The display outputs SHALL update exactly one cycle after any wr_en or effective step; a written value SHALL appear on disp_* on the cycle after its wr_en.
REQ-026 The FSM SHALL have three states:
- EMPTY: count==0; disp_* = 0.
- LIVE: view_offset==0.
- BROWSE: view_offset>0.
REQ-027 FSM transitions SHALL be:
- EMPTY -> LIVE on wr_en.
- LIVE -> BROWSE on a prev edge when count>1.
- BROWSE -> LIVE on wr_en, or when a next edge reaches offset 0.
- any state -> EMPTY on clear.
REQ-028 Event priority SHALL be clear > wr_en > button edges; a button edge coincident with wr_en SHALL be discarded.
REQ-029 Simultaneous prev and next edges SHALL be ignored.
REQ-030 Button edges while EMPTY SHALL be ignored.
REQ-031 clear SHALL zero wr_ptr, count, view_offset and disp_*; memory contents are don't-care.

Reset
REQ-032 rst SHALL asynchronously zero wr_ptr, count, view_offset, disp_result, disp_rem and disp_div_flag, and the edge-detector history registers; the FSM SHALL enter EMPTY.
REQ-033 Memory array SHALL NOT be reset (allows inference as distributed RAM).
REQ-034 Deassertion of rst mid-browse SHALL leave the block EMPTY; no stale entry SHALL become visible.

Structure
REQ-035 A shared package SHALL hold DEPTH, ADDR_W, entry field widths and the FSM state encoding.
REQ-036 Rising-edge detection SHALL be a sub-module, btn_edge_detect, instantiated once per button.

Verification
REQ-037 Apply reset, then write 0x0005, 0x0003, 0x000F -> disp_result = 0x000F, count = 3, view_offset = 0.
REQ-038 Continuing from REQ-037: two prev edges then a third prev edge -> disp_result = 0x0003, then 0x0005, then remains 0x0005 with view_offset = 2.
REQ-039 Write 10 entries 0x0001..0x000A with DEPTH = 8 -> full = 1; seven prev edges show 0x0003 (oldest); 0x0001 and 0x0002 are gone.
REQ-040 In BROWSE at offset 2, wr_en of 0x0042 coincident with a prev edge -> view_offset = 0, disp_result = 0x0042.
REQ-041 Write result 0x0002 with rem = 4'h1 and div_flag = 1, then assert clear -> next cycle empty = 1, disp_* = 0; prev edges cause no change.
REQ-042 Assert rst asynchronously (between clock edges) while at offset 3 -> outputs zero immediately and count = 0.

Source files
------------

// File: rtl/result_history_buffer_pkg.sv
// Shared sizing, entry layout and view-FSM encoding for the result history buffer.
package result_history_buffer_pkg;

  localparam int HIST_DEPTH  = 8;
  localparam int HIST_ADDR_W = 3;
  localparam int RESULT_W    = 16;
  localparam int REM_W       = 4;

  typedef struct packed {
    logic                div_flag;
    logic [REM_W-1:0]    rem;
    logic [RESULT_W-1:0] result;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LIVE   = 2'd1,
    ST_BROWSE = 2'd2
  } state_t;

endpackage

// File: rtl/result_history_buffer_btn_edge_detect.sv
// Rising-edge detector for a debounced button level; one pulse per press.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic btn_q;
  logic btn_d;

  always_comb begin
    btn_d = btn;
    rise  = btn & ~btn_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn_d;
  end

endmodule

// File: rtl/result_history_buffer.sv
// Circular history of ALU results with a browsable view that the buttons step
// through; the viewed entry is presented on registered display outputs.
module result_history_buffer
  import result_history_buffer_pkg::*;
#(
  parameter int DEPTH  = HIST_DEPTH,
  parameter int ADDR_W = HIST_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [RESULT_W-1:0] result_in,
  input  logic [REM_W-1:0]    rem_in,
  input  logic                div_flag_in,
  input  logic                prev_btn,
  input  logic                next_btn,
  input  logic                clear,
  output logic [RESULT_W-1:0] disp_result,
  output logic [REM_W-1:0]    disp_rem,
  output logic                disp_div_flag,
  output logic [ADDR_W-1:0]   view_offset,
  output logic [ADDR_W:0]     count,
  output logic                empty,
  output logic                full
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  entry_t            mem_q [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] view_offset_q, view_offset_d;
  entry_t            disp_q, disp_d;
  entry_t            wr_entry;
  logic [ADDR_W-1:0] rd_addr;
  logic              mem_we;
  logic              prev_edge, next_edge, step;

  btn_edge_detect u_prev_edge (.clk(clk), .rst(rst), .btn(prev_btn), .rise(prev_edge));
  btn_edge_detect u_next_edge (.clk(clk), .rst(rst), .btn(next_btn), .rise(next_edge));

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    view_offset_d = view_offset_q;
    disp_d        = disp_q;
    mem_we        = 1'b0;
    rd_addr       = '0;
    wr_entry      = '{div_flag: div_flag_in, rem: rem_in, result: result_in};
    step          = (prev_edge ^ next_edge) && (state_q != ST_EMPTY);

    if (clear) begin
      state_d       = ST_EMPTY;
      wr_ptr_d      = '0;
      count_d       = '0;
      view_offset_d = '0;
      disp_d        = '0;
    end else if (wr_en) begin
      // The new entry is shown straight from the inputs; memory is written this same edge.
      mem_we        = 1'b1;
      wr_ptr_d      = wr_ptr_q + ADDR_W'(1);
      count_d       = (count_q == DEPTH_C) ? count_q : count_q + (ADDR_W+1)'(1);
      view_offset_d = '0;
      disp_d        = wr_entry;
      state_d       = ST_LIVE;
    end else if (step) begin
      if (prev_edge && ({1'b0, view_offset_q} < count_q - (ADDR_W+1)'(1)))
        view_offset_d = view_offset_q + ADDR_W'(1);
      else if (next_edge && (view_offset_q != '0))
        view_offset_d = view_offset_q - ADDR_W'(1);
      rd_addr = wr_ptr_q - ADDR_W'(1) - view_offset_d;
      if (view_offset_d != view_offset_q) disp_d = mem_q[rd_addr];
      state_d = (view_offset_d == '0) ? ST_LIVE : ST_BROWSE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      view_offset_q <= '0;
      disp_q        <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      view_offset_q <= view_offset_d;
      disp_q        <= disp_d;
    end
  end

  // Storage is deliberately left unreset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign disp_result   = disp_q.result;
  assign disp_rem      = disp_q.rem;
  assign disp_div_flag = disp_q.div_flag;
  assign view_offset   = view_offset_q;
  assign count         = count_q;
  assign empty         = (count_q == '0);
  assign full          = (count_q == DEPTH_C);

endmodule

// File: tb/tb_result_history_buffer.sv
// Self-checking bench for result_history_buffer: vector table plus hand-written
// sequences for wraparound and asynchronous reset, checked through a scoreboard.
module tb_result_history_buffer;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [15:0] result_in;
  logic [3:0]  rem_in;
  logic        div_flag_in;
  logic        prev_btn;
  logic        next_btn;
  logic        clear;
  logic [15:0] disp_result;
  logic [3:0]  disp_rem;
  logic        disp_div_flag;
  logic [2:0]  view_offset;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  typedef struct {
    string       name;
    logic        wr_en;
    logic [15:0] result;
    logic [3:0]  rem;
    logic        div;
    logic        prev;
    logic        next;
    logic        clear;
    logic [15:0] e_res;
    logic [3:0]  e_rem;
    logic        e_div;
    logic [2:0]  e_off;
    logic [3:0]  e_cnt;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [3:0]  rem;
    logic        div;
    logic [2:0]  off;
    logic [3:0]  cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   vec_count;
  int   miscompares;

  result_history_buffer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .result_in(result_in), .rem_in(rem_in),
    .div_flag_in(div_flag_in), .prev_btn(prev_btn), .next_btn(next_btn), .clear(clear),
    .disp_result(disp_result), .disp_rem(disp_rem), .disp_div_flag(disp_div_flag),
    .view_offset(view_offset), .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic w, logic [15:0] r, logic [3:0] rm, logic d,
                              logic p, logic n, logic c, logic [15:0] er, logic [3:0] erm,
                              logic ed, logic [2:0] eo, logic [3:0] ec);
    vec_t v;
    v.name = name; v.wr_en = w; v.result = r; v.rem = rm; v.div = d;
    v.prev = p; v.next = n; v.clear = c;
    v.e_res = er; v.e_rem = erm; v.e_div = ed; v.e_off = eo; v.e_cnt = ec;
    return v;
  endfunction

  function automatic exp_t expOf(vec_t v);
    exp_t e;
    e.name = v.name; e.res = v.e_res; e.rem = v.e_rem; e.div = v.e_div;
    e.off = v.e_off; e.cnt = v.e_cnt;
    return e;
  endfunction

  // Pops the oldest expectation and compares every observable output against it.
  task automatic checkOutput();
    exp_t e;
    logic e_empty, e_full;
    vec_count++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_underflow: got no expectation, want one queued");
      return;
    end
    e = exp_q.pop_front();
    e_empty = (e.cnt == 4'd0);
    e_full  = (e.cnt == 4'd8);
    if (disp_result !== e.res || disp_rem !== e.rem || disp_div_flag !== e.div ||
        view_offset !== e.off || count !== e.cnt || empty !== e_empty || full !== e_full) begin
      miscompares++;
      $display("[TB] FAIL %s: got res=%h rem=%h div=%b off=%0d cnt=%0d empty=%b full=%b, want res=%h rem=%h div=%b off=%0d cnt=%0d empty=%b full=%b",
               e.name, disp_result, disp_rem, disp_div_flag, view_offset, count, empty, full,
               e.res, e.rem, e.div, e.off, e.cnt, e_empty, e_full);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    wr_en = v.wr_en; result_in = v.result; rem_in = v.rem; div_flag_in = v.div;
    prev_btn = v.prev; next_btn = v.next; clear = v.clear;
    exp_q.push_back(expOf(v));
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, want finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_count = 0; miscompares = 0;
    rst = 1'b1; wr_en = 0; result_in = '0; rem_in = '0; div_flag_in = 0;
    prev_btn = 0; next_btn = 0; clear = 0;

    //              name              wr res      rem  dv pv nx cl  e_res    erm  ed off cnt
    vecs.push_back(mk("idle_empty",     0, 16'h0,  4'h0, 0, 0, 0, 0, 16'h0000, 4'h0, 0, 0, 0));
    vecs.push_back(mk("prev_in_empty",  0, 16'h0,  4'h0, 0, 1, 0, 0, 16'h0000, 4'h0, 0, 0, 0));
    vecs.push_back(mk("rel_in_empty",   0, 16'h0,  4'h0, 0, 0, 0, 0, 16'h0000, 4'h0, 0, 0, 0));
    vecs.push_back(mk("wr_0005",        1, 16'h5,  4'h0, 0, 0, 0, 0, 16'h0005, 4'h0, 0, 0, 1));
    vecs.push_back(mk("wr_0003",        1, 16'h3,  4'h0, 0, 0, 0, 0, 16'h0003, 4'h0, 0, 0, 2));
    vecs.push_back(mk("wr_000F",        1, 16'hF,  4'h0, 0, 0, 0, 0, 16'h000F, 4'h0, 0, 0, 3));
    vecs.push_back(mk("prev1",          0, 16'h0,  4'h0, 0, 1, 0, 0, 16'h0003, 4'h0, 0, 1, 3));
    vecs.push_back(mk("prev1_held",     0, 16'h0,  4'h0, 0, 1, 0, 0, 16'h0003, 4'h0, 0, 1, 3));
    vecs.push_back(mk("rel1",           0, 16'h0,  4'h0, 0, 0, 0, 0, 16'h0003, 4'h0, 0, 1, 3));
    vecs.push_back(mk("prev2",          0, 16'h0,  4'h0, 0, 1, 0, 0, 16'h0005, 4'h0, 0, 2, 3));
    vecs.push_back(mk("rel2",           0, 16'h0,  4'h0, 0, 0, 0, 0, 16'h0005, 4'h0, 0, 2, 3));
    vecs.push_back(mk("prev3_sat",      0, 16'h0,  4'h0, 0, 1, 0, 0, 16'h0005, 4'h0, 0, 2, 3));
    vecs.push_back(mk("rel3",           0, 16'h0,  4'h0, 0, 0, 0, 0, 16'h0005, 4'h0, 0, 2, 3));
    vecs.push_back(mk("next1",          0, 16'h0,  4'h0, 0, 0, 1, 0, 16'h0003, 4'h0, 0, 1, 3));
    vecs.push_back(mk("rel_next1",      0, 16'h0,  4'h0, 0, 0, 0, 0, 16'h0003, 4'h0, 0, 1, 3));
    vecs.push_back(mk("both_edges",     0, 16'h0,  4'h0, 0, 1, 1, 0, 16'h0003, 4'h0, 0, 1, 3));
    vecs.push_back(mk("rel_both",       0, 16'h0,  4'h0, 0, 0, 0, 0, 16'h0003, 4'h0, 0, 1, 3));
    vecs.push_back(mk("prev_to_off2",   0, 16'h0,  4'h0, 0, 1, 0, 0, 16'h0005, 4'h0, 0, 2, 3));
    vecs.push_back(mk("rel4",           0, 16'h0,  4'h0, 0, 0, 0, 0, 16'h0005, 4'h0, 0, 2, 3));
    vecs.push_back(mk("wr_42_with_prev",1, 16'h42, 4'h0, 0, 1, 0, 0, 16'h0042, 4'h0, 0, 0, 4));
    vecs.push_back(mk("rel5",           0, 16'h0,  4'h0, 0, 0, 0, 0, 16'h0042, 4'h0, 0, 0, 4));
    vecs.push_back(mk("next_at_live",   0, 16'h0,  4'h0, 0, 0, 1, 0, 16'h0042, 4'h0, 0, 0, 4));
    vecs.push_back(mk("rel6",           0, 16'h0,  4'h0, 0, 0, 0, 0, 16'h0042, 4'h0, 0, 0, 4));
    vecs.push_back(mk("wr_0002_div",    1, 16'h2,  4'h1, 1, 0, 0, 0, 16'h0002, 4'h1, 1, 0, 5));
    vecs.push_back(mk("clear",          0, 16'h0,  4'h0, 0, 0, 0, 1, 16'h0000, 4'h0, 0, 0, 0));
    vecs.push_back(mk("prev_after_clr", 0, 16'h0,  4'h0, 0, 1, 0, 0, 16'h0000, 4'h0, 0, 0, 0));
    vecs.push_back(mk("rel7",           0, 16'h0,  4'h0, 0, 0, 0, 0, 16'h0000, 4'h0, 0, 0, 0));
    vecs.push_back(mk("clear_beats_wr", 1, 16'h77, 4'h3, 1, 0, 0, 1, 16'h0000, 4'h0, 0, 0, 0));
    vecs.push_back(mk("wr_0011",        1, 16'h11, 4'hA, 0, 0, 0, 0, 16'h0011, 4'hA, 0, 0, 1));
    vecs.push_back(mk("prev_count1",    0, 16'h0,  4'h0, 0, 1, 0, 0, 16'h0011, 4'hA, 0, 0, 1));
    vecs.push_back(mk("rel8",           0, 16'h0,  4'h0, 0, 0, 0, 0, 16'h0011, 4'hA, 0, 0, 1));
    vecs.push_back(mk("clear2",         0, 16'h0,  4'h0, 0, 0, 0, 1, 16'h0000, 4'h0, 0, 0, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(expOf(mk("reset_state", 0, 0, 0, 0, 0, 0, 0, 16'h0, 4'h0, 0, 0, 0)));
    checkOutput();
    rst = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Ten writes into eight slots: the two oldest are overwritten.
    for (int k = 1; k <= 10; k++)
      applyStimulus(mk($sformatf("fill_%0d", k), 1, 16'(k), 4'h0, 0, 0, 0, 0,
                       16'(k), 4'h0, 0, 0, 4'((k > 8) ? 8 : k)));
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(mk($sformatf("wrap_prev_%0d", k), 0, 0, 0, 0, 1, 0, 0,
                       16'(10 - k), 4'h0, 0, 3'(k), 4'd8));
      applyStimulus(mk($sformatf("wrap_rel_%0d", k), 0, 0, 0, 0, 0, 0, 0,
                       16'(10 - k), 4'h0, 0, 3'(k), 4'd8));
    end
    applyStimulus(mk("wrap_prev_sat", 0, 0, 0, 0, 1, 0, 0, 16'h0003, 4'h0, 0, 3'd7, 4'd8));
    applyStimulus(mk("wrap_rel_sat",  0, 0, 0, 0, 0, 0, 0, 16'h0003, 4'h0, 0, 3'd7, 4'd8));
    for (int k = 6; k >= 3; k--) begin
      applyStimulus(mk($sformatf("wrap_next_to_%0d", k), 0, 0, 0, 0, 0, 1, 0,
                       16'(10 - k), 4'h0, 0, 3'(k), 4'd8));
      applyStimulus(mk($sformatf("wrap_nrel_%0d", k), 0, 0, 0, 0, 0, 0, 0,
                       16'(10 - k), 4'h0, 0, 3'(k), 4'd8));
    end

    // Asynchronous reset between clock edges while browsing at offset 3.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.push_back(expOf(mk("async_rst_now", 0, 0, 0, 0, 0, 0, 0, 16'h0, 4'h0, 0, 0, 0)));
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(mk("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 16'h0, 4'h0, 0, 0, 0));
    applyStimulus(mk("post_rst_prev", 0, 0, 0, 0, 1, 0, 0, 16'h0, 4'h0, 0, 0, 0));
    applyStimulus(mk("post_rst_rel",  0, 0, 0, 0, 0, 0, 0, 16'h0, 4'h0, 0, 0, 0));
    applyStimulus(mk("post_rst_wr",   1, 16'hBEEF, 4'h7, 1, 0, 0, 0, 16'hBEEF, 4'h7, 1, 0, 1));

    if (exp_q.size() != 0) begin
      vec_count++;
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: got %0d pending, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
